// File: rtl/fft_spi_pkg.sv
// Shared definitions for the FFT result SPI link (output block and the fft_spi_in receiver).
package fft_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int BYTE_W      = 8;
    localparam int DEF_N       = 32;
    localparam int DEF_MSB     = 16;
    localparam int DEF_TIMEOUT = 1024;

    // Counter width that stays legal for a count range of 1.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_slave_byte_rx.sv
// SPI mode-0 byte receiver: synchronises sclk/mosi/cs into clk, detects sclk edges
// and shifts bits MSB-first into bytes.
module spi_slave_byte_rx
    import fft_spi_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              cs,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              byte_valid,
    output logic              partial_err,
    output logic              cs_sync,
    output logic              sclk_edge
);

    logic [2:0]        sclk_s;
    logic [1:0]        mosi_s;
    logic [2:0]        cs_s;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-2:0] shreg;
    logic              sclk_rise;
    logic              cs_rise;
    logic              sample;
    logic              last_bit;

    // cs resets high so a reset never manufactures a cs rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_s <= '0;
            mosi_s <= '0;
            cs_s   <= '1;
        end else begin
            sclk_s <= {sclk_s[1:0], sclk};
            mosi_s <= {mosi_s[0], mosi};
            cs_s   <= {cs_s[1:0], cs};
        end
    end

    assign cs_sync   = cs_s[1];
    assign cs_rise   = cs_s[1] & ~cs_s[2];
    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_edge = sclk_s[1] ^ sclk_s[2];

    // A rising sclk in the same cycle as the cs rise still belongs to the byte.
    assign sample   = sclk_rise & (~cs_s[1] | cs_rise);
    assign last_bit = sample && (bit_cnt == 3'd7);

    // byte_valid is a single-cycle strobe with no backpressure: the consumer must take
    // rx_byte in the cycle byte_valid is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt     <= '0;
            shreg       <= '0;
            rx_byte     <= '0;
            byte_valid  <= 1'b0;
            partial_err <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            partial_err <= 1'b0;
            if (sample) begin
                shreg <= {shreg[BYTE_W-3:0], mosi_s[1]};
                if (last_bit) begin
                    bit_cnt    <= '0;
                    byte_valid <= 1'b1;
                    rx_byte    <= {shreg, mosi_s[1]};
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
            if (cs_rise && !last_bit && (bit_cnt != 3'd0 || sample)) begin
                partial_err <= 1'b1;
                bit_cnt     <= '0;
            end
        end
    end

endmodule

// File: rtl/fft_spi_in.sv
// SPI slave frame receiver: assembles bytes into N words of MSB bits in a shadow buffer
// and publishes each complete frame on data_bus with a one-cycle frame_valid.
module fft_spi_in
    import fft_spi_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int MSB     = DEF_MSB,      // multiple of 8
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             cs,
    output logic [N*MSB-1:0] data_bus,
    output logic             frame_valid,
    output logic             busy,
    output logic             rx_err,
    output state_t           dbg_state
);

    localparam int BPW = MSB / BYTE_W;
    localparam int AW  = cnt_w(N);
    localparam int BW  = cnt_w(BPW);
    localparam int TW  = $clog2(TIMEOUT + 1);

    state_t            state;
    state_t            state_nx;
    logic [BYTE_W-1:0] rx_byte;
    logic              byte_valid;
    logic              partial_err;
    logic              cs_sync;
    logic              sclk_edge;
    logic [BW-1:0]     byte_idx;
    logic [AW-1:0]     word_addr;
    logic [MSB-1:0]    word_acc;
    logic [MSB-1:0]    word_next;
    logic [N*MSB-1:0]  shadow;
    logic              last_wr;
    logic [TW-1:0]     idle_cnt;
    logic              idle_inc;
    logic              timeout_hit;
    logic              abort;
    logic              byte_last;
    logic              word_last;

    spi_slave_byte_rx u_byte_rx (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs          (cs),
        .rx_byte     (rx_byte),
        .byte_valid  (byte_valid),
        .partial_err (partial_err),
        .cs_sync     (cs_sync),
        .sclk_edge   (sclk_edge)
    );

    assign word_next = (word_acc << BYTE_W) | MSB'(rx_byte);
    assign byte_last = (byte_idx == BW'(BPW - 1));
    assign word_last = (word_addr == AW'(N - 1));

    assign idle_inc    = (state == ST_ACTIVE) && cs_sync && !sclk_edge;
    assign timeout_hit = idle_inc && (idle_cnt == TW'(TIMEOUT - 1));
    assign abort       = partial_err | timeout_hit;

    // Counters wrap to zero on the last word, so DONE finds them already cleared and a
    // byte arriving right behind the frame starts the next one cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx  <= '0;
            word_addr <= '0;
            word_acc  <= '0;
            shadow    <= '0;
            last_wr   <= 1'b0;
        end else if (abort) begin
            byte_idx  <= '0;
            word_addr <= '0;
            word_acc  <= '0;
            last_wr   <= 1'b0;
        end else begin
            last_wr <= 1'b0;
            if (byte_valid) begin
                if (byte_last) begin
                    for (int w = 0; w < N; w++) begin
                        if (word_addr == AW'(w)) begin
                            shadow[w*MSB +: MSB] <= word_next;
                        end
                    end
                    byte_idx <= '0;
                    word_acc <= '0;
                    if (word_last) begin
                        word_addr <= '0;
                        last_wr   <= 1'b1;
                    end else begin
                        word_addr <= word_addr + AW'(1);
                    end
                end else begin
                    byte_idx <= byte_idx + BW'(1);
                    word_acc <= word_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !idle_inc) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (last_wr) begin
                    state_nx = ST_DONE;
                end else if (byte_valid && !abort) begin
                    state_nx = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (last_wr) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = (byte_valid && !abort) ? ST_ACTIVE : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // data_bus only moves on the DONE copy, so aborted frames never reach it.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_bus    <= '0;
            frame_valid <= 1'b0;
            rx_err      <= 1'b0;
        end else begin
            frame_valid <= (state == ST_DONE);
            rx_err      <= abort;
            if (state == ST_DONE) begin
                data_bus <= shadow;
            end
        end
    end

    assign busy      = (state == ST_ACTIVE);
    assign dbg_state = state;

endmodule

// File: tb/tb_fft_spi_in.sv
// Bench for fft_spi_in: drives SPI mode-0 traffic at clk/8 and checks frames, errors and timing.
module tb_fft_spi_in;
    import fft_spi_pkg::*;

    localparam int N       = 4;
    localparam int MSB     = 16;
    localparam int TIMEOUT = 200;
    localparam int DW      = N * MSB;
    localparam int BPW     = MSB / 8;
    localparam int NB      = N * BPW;
    localparam int HALF    = 4;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          sclk = 1'b0;
    logic          mosi = 1'b0;
    logic          cs   = 1'b1;
    logic [DW-1:0] data_bus;
    logic          frame_valid;
    logic          busy;
    logic          rx_err;
    state_t        dbg_state;

    int checks   = 0;
    int failures = 0;

    fft_spi_in #(.N(N), .MSB(MSB), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs          (cs),
        .data_bus    (data_bus),
        .frame_valid (frame_valid),
        .busy        (busy),
        .rx_err      (rx_err),
        .dbg_state   (dbg_state)
    );

    // clock / reset and cycle index (value = number of the most recent posedge)
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: frames and error pulses observed on the negative edge
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int fv_count  = 0;
    int err_count = 0;
    int fv_edge   = 0;
    int err_edge  = 0;
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                fv_count++;
                fv_edge = cyc;
                got_q.push_back(data_bus);
            end
            if (rx_err) begin
                err_count++;
                err_edge = cyc;
            end
        end
    end

    // reference model: byte k of the frame lands in word k/BPW, most significant byte first
    logic [7:0] tx_q[$];
    logic [7:0] stream_q[$];
    function automatic logic [DW-1:0] build_frame();
        logic [DW-1:0] f;
        f = '0;
        for (int i = 0; i < NB; i++) begin
            f[(i / BPW) * MSB + (BPW - 1 - (i % BPW)) * 8 +: 8] = tx_q[i];
        end
        return f;
    endfunction

    // driver tasks
    int rise_edge  = 0;
    int last_cs_up = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = b[i];
            tick(HALF);
            sclk = 1'b1;
            rise_edge = cyc + 1;
            tick(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        cs = 1'b0;
        tick(HALF);
        spi_bits(b, 8);
        tick(HALF);
        cs = 1'b1;
        last_cs_up = cyc;
        tick(gap);
    endtask

    task automatic send_frame(input int gap_lo, input int gap_hi);
        for (int i = 0; i < NB; i++) begin
            send_byte(tx_q[i], $urandom_range(gap_lo, gap_hi));
        end
        exp_q.push_back(build_frame());
    endtask

    task automatic random_bytes();
        tx_q.delete();
        for (int i = 0; i < NB; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k;
        k = 0;
        while (fv_count < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        #1;
    endtask

    // scenarios
    task automatic test_reset();
        @(negedge clk);
        tick(4);
        rst = 1'b0;
        tick(2);
        #1;
        checks++; if (data_bus !== '0) begin failures++; $display("FAIL reset_data_bus got=%h exp=0", data_bus); end
        checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (rx_err !== 1'b0) begin failures++; $display("FAIL reset_rx_err got=%b exp=0", rx_err); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_fixed_frame();
        logic [7:0] fixed [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        logic [DW-1:0] g;
        logic [DW-1:0] e;
        int fv0;
        int err0;
        fv0 = fv_count;
        err0 = err_count;
        tx_q.delete();
        foreach (fixed[i]) tx_q.push_back(fixed[i]);
        send_frame(3, 3);
        wait_frames(fv0 + 1, 200);
        checks++; if (fv_count !== fv0 + 1) begin failures++; $display("FAIL fixed_frame_count got=%0d exp=%0d", fv_count - fv0, 1); end
        checks++; if (fv_edge - rise_edge !== 5) begin failures++; $display("FAIL fixed_latency got=%0d exp=5", fv_edge - rise_edge); end
        checks++; if (err_count !== err0) begin failures++; $display("FAIL fixed_rx_err got=%0d exp=%0d", err_count - err0, 0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL fixed_busy got=%b exp=0", busy); end
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL fixed_model got=%h exp=%h", g, e); end
            checks++; if (g !== 64'hDEF0_9ABC_5678_1234) begin failures++; $display("FAIL fixed_data got=%h exp=%h", g, 64'hDEF0_9ABC_5678_1234); end
        end else begin
            checks++; failures++; $display("FAIL fixed_no_frame got=%0d exp=1", got_q.size());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_partial_abort();
        logic [7:0] fixed [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        logic [DW-1:0] bus0;
        logic [DW-1:0] g;
        logic [DW-1:0] e;
        int fv0;
        int err0;
        fv0 = fv_count;
        err0 = err_count;
        bus0 = data_bus;
        for (int i = 0; i < 4; i++) send_byte(fixed[i], 3);
        cs = 1'b0;
        tick(HALF);
        spi_bits(fixed[4], 3);
        tick(HALF);
        cs = 1'b1;
        tick(10);
        #1;
        checks++; if (err_count !== err0 + 1) begin failures++; $display("FAIL abort_rx_err got=%0d exp=1", err_count - err0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
        checks++; if (data_bus !== bus0) begin failures++; $display("FAIL abort_data_bus got=%h exp=%h", data_bus, bus0); end
        checks++; if (fv_count !== fv0) begin failures++; $display("FAIL abort_frame_valid got=%0d exp=0", fv_count - fv0); end
        tx_q.delete();
        foreach (fixed[i]) tx_q.push_back(fixed[i] + 8'd1);
        send_frame(3, 6);
        wait_frames(fv0 + 1, 200);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL resend_model got=%h exp=%h", g, e); end
            checks++; if (g !== 64'hDFF1_9BBD_5779_1335) begin failures++; $display("FAIL resend_data got=%h exp=%h", g, 64'hDFF1_9BBD_5779_1335); end
        end else begin
            checks++; failures++; $display("FAIL resend_no_frame got=%0d exp=1", got_q.size());
        end
        checks++; if (err_count !== err0 + 1) begin failures++; $display("FAIL resend_rx_err got=%0d exp=1", err_count - err0); end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout();
        logic [DW-1:0] bus0;
        int fv0;
        int err0;
        fv0 = fv_count;
        err0 = err_count;
        bus0 = data_bus;
        random_bytes();
        for (int i = 0; i < 4; i++) send_byte(tx_q[i], 3);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL timeout_busy_mid got=%b exp=1", busy); end
        tick(TIMEOUT + 10);
        #1;
        checks++; if (err_count !== err0 + 1) begin failures++; $display("FAIL timeout_rx_err got=%0d exp=1", err_count - err0); end
        // two synchroniser cycles before cs_sync is high, then TIMEOUT idle counts
        checks++; if (err_edge - last_cs_up !== TIMEOUT + 2) begin failures++; $display("FAIL timeout_cycle got=%0d exp=%0d", err_edge - last_cs_up, TIMEOUT + 2); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL timeout_busy got=%b exp=0", busy); end
        checks++; if (fv_count !== fv0) begin failures++; $display("FAIL timeout_frame_valid got=%0d exp=0", fv_count - fv0); end
        checks++; if (data_bus !== bus0) begin failures++; $display("FAIL timeout_data_bus got=%h exp=%h", data_bus, bus0); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] g;
        logic [DW-1:0] e;
        int fv0;
        int err0;
        fv0 = fv_count;
        err0 = err_count;
        stream_q.delete();
        for (int f = 0; f < 2; f++) begin
            random_bytes();
            exp_q.push_back(build_frame());
            foreach (tx_q[i]) stream_q.push_back(tx_q[i]);
        end
        cs = 1'b0;
        tick(HALF);
        foreach (stream_q[i]) spi_bits(stream_q[i], 8);
        tick(HALF);
        cs = 1'b1;
        tick(4);
        wait_frames(fv0 + 2, 200);
        checks++; if (fv_count !== fv0 + 2) begin failures++; $display("FAIL b2b_frame_count got=%0d exp=2", fv_count - fv0); end
        checks++; if (err_count !== err0) begin failures++; $display("FAIL b2b_rx_err got=%0d exp=0", err_count - err0); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++; $display("FAIL b2b_missing got=none exp=%h", e);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin failures++; $display("FAIL b2b_data got=%h exp=%h", g, e); end
                if (exp_q.size() == 0 && data_bus !== e) begin failures++; $display("FAIL b2b_final_bus got=%h exp=%h", data_bus, e); end
            end
        end
        got_q.delete();
    endtask

    task automatic test_rst_mid_frame();
        logic [DW-1:0] g;
        logic [DW-1:0] e;
        int fv0;
        int err0;
        random_bytes();
        send_byte(tx_q[0], 3);
        send_byte(tx_q[1], 3);
        cs = 1'b0;
        tick(HALF);
        spi_bits(tx_q[2], 3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        err0 = err_count;
        tick(HALF);
        cs = 1'b1;
        tick(10);
        #1;
        checks++; if (data_bus !== '0) begin failures++; $display("FAIL rst_mid_data_bus got=%h exp=0", data_bus); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_mid_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        checks++; if (err_count !== err0) begin failures++; $display("FAIL rst_mid_rx_err got=%0d exp=0", err_count - err0); end
        fv0 = fv_count;
        random_bytes();
        send_frame(2, 12);
        wait_frames(fv0 + 1, 200);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            checks++; if (g !== e) begin failures++; $display("FAIL rst_after_data got=%h exp=%h", g, e); end
        end else begin
            checks++; failures++; $display("FAIL rst_after_no_frame got=%0d exp=1", got_q.size());
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_cs_high_ignored();
        logic [DW-1:0] bus0;
        int fv0;
        int err0;
        int busy_seen;
        int bad_state;
        fv0 = fv_count;
        err0 = err_count;
        bus0 = data_bus;
        busy_seen = 0;
        bad_state = 0;
        cs = 1'b1;
        mosi = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick(HALF);
            sclk = ~sclk;
            #1;
            if (busy) busy_seen++;
            if (dbg_state != ST_IDLE) bad_state++;
        end
        sclk = 1'b0;
        mosi = 1'b0;
        tick(10);
        #1;
        checks++; if (busy_seen !== 0) begin failures++; $display("FAIL cs_high_busy got=%0d exp=0", busy_seen); end
        checks++; if (bad_state !== 0) begin failures++; $display("FAIL cs_high_state got=%0d exp=0", bad_state); end
        checks++; if (fv_count !== fv0) begin failures++; $display("FAIL cs_high_frame_valid got=%0d exp=0", fv_count - fv0); end
        checks++; if (err_count !== err0) begin failures++; $display("FAIL cs_high_rx_err got=%0d exp=0", err_count - err0); end
        checks++; if (data_bus !== bus0) begin failures++; $display("FAIL cs_high_data_bus got=%h exp=%h", data_bus, bus0); end
    endtask

    task automatic test_random_frames();
        logic [DW-1:0] g;
        logic [DW-1:0] e;
        int fv0;
        int err0;
        for (int f = 0; f < 3; f++) begin
            fv0 = fv_count;
            err0 = err_count;
            random_bytes();
            send_frame(2, 30);
            wait_frames(fv0 + 1, 200);
            checks++; if (err_count !== err0) begin failures++; $display("FAIL random_rx_err frame=%0d got=%0d exp=0", f, err_count - err0); end
            if (got_q.size() > 0 && exp_q.size() > 0) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                checks++; if (g !== e) begin failures++; $display("FAIL random_data frame=%0d got=%h exp=%h", f, g, e); end
            end else begin
                checks++; failures++; $display("FAIL random_no_frame frame=%0d got=%0d exp=1", f, got_q.size());
            end
            got_q.delete();
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_fixed_frame();
        test_partial_abort();
        test_timeout();
        test_back_to_back();
        test_rst_mid_frame();
        test_cs_high_ignored();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
